// File: rtl/image_sobel_4p.sv
// 4-lane 3x3 Sobel edge magnitude, 3-cycle pipeline with regenerated sof/eol/eof markers.
// Optional binary edge map when SOBEL_THRESH_EN is defined (pixel >= i_thresh -> all-ones, else 0).
module image_sobel_4p #(
   parameter int PARALLEL_NUM = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int H_OUT        = 478,
   parameter int V_OUT        = 1078
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_en,
   input  logic [PARALLEL_NUM*DATA_WIDTH-1:0] i_temp_11,
   input  logic [PARALLEL_NUM*DATA_WIDTH-1:0] i_temp_12,
   input  logic [PARALLEL_NUM*DATA_WIDTH-1:0] i_temp_13,
   input  logic [PARALLEL_NUM*DATA_WIDTH-1:0] i_temp_21,
   input  logic [PARALLEL_NUM*DATA_WIDTH-1:0] i_temp_22,
   input  logic [PARALLEL_NUM*DATA_WIDTH-1:0] i_temp_23,
   input  logic [PARALLEL_NUM*DATA_WIDTH-1:0] i_temp_31,
   input  logic [PARALLEL_NUM*DATA_WIDTH-1:0] i_temp_32,
   input  logic [PARALLEL_NUM*DATA_WIDTH-1:0] i_temp_33,
   input  logic [DATA_WIDTH-1:0]              i_thresh,
   output logic                               o_en,
   output logic [PARALLEL_NUM*DATA_WIDTH-1:0] o_data,
   output logic                               o_sof,
   output logic                               o_eol,
   output logic                               o_eof
);

   localparam int SW = DATA_WIDTH + 2;
   localparam int MW = DATA_WIDTH + 3;
   localparam int CW = 11;
   localparam logic [CW-1:0] H_LAST = CW'(H_OUT - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_OUT - 1);

   function automatic logic [SW-1:0] wsum(input logic [DATA_WIDTH-1:0] a, b, c);
      return SW'(a) + (SW'(b) << 1) + SW'(c);
   endfunction

   function automatic logic [MW-1:0] abs_diff(input logic [SW-1:0] a, b);
      logic signed [MW-1:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return (d < 0) ? MW'(-d) : MW'(d);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] sat_pix(input logic [MW-1:0] m);
      return (m > MW'({DATA_WIDTH{1'b1}})) ? {DATA_WIDTH{1'b1}} : m[DATA_WIDTH-1:0];
   endfunction

`ifdef SOBEL_THRESH_EN
   function automatic logic [DATA_WIDTH-1:0] out_pix(input logic [MW-1:0] m,
                                                     input logic [DATA_WIDTH-1:0] thr);
      return (sat_pix(m) >= thr) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
   endfunction
`else
   function automatic logic [DATA_WIDTH-1:0] out_pix(input logic [MW-1:0] m,
                                                     input logic [DATA_WIDTH-1:0] thr);
      logic unused_thr;
      unused_thr = ^thr;
      return sat_pix(m);
   endfunction
`endif

   logic [PARALLEL_NUM-1:0][SW-1:0] gxp_p0, gxn_p0, gyp_p0, gyn_p0;
   logic                            vld_p0;
   logic [PARALLEL_NUM-1:0][MW-1:0] mag_p1;
   logic                            vld_p1;
   logic [CW-1:0]                   h_cnt, v_cnt;

   // Stage 1: positive/negative weighted column and row sums per lane
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld_p0 <= 1'b0;
         gxp_p0 <= '0;
         gxn_p0 <= '0;
         gyp_p0 <= '0;
         gyn_p0 <= '0;
      end else begin
         vld_p0 <= i_en;
         if (i_en) begin
            for (int k = 0; k < PARALLEL_NUM; k++) begin
               gxp_p0[k] <= wsum(i_temp_13[k*DATA_WIDTH +: DATA_WIDTH],
                                 i_temp_23[k*DATA_WIDTH +: DATA_WIDTH],
                                 i_temp_33[k*DATA_WIDTH +: DATA_WIDTH]);
               gxn_p0[k] <= wsum(i_temp_11[k*DATA_WIDTH +: DATA_WIDTH],
                                 i_temp_21[k*DATA_WIDTH +: DATA_WIDTH],
                                 i_temp_31[k*DATA_WIDTH +: DATA_WIDTH]);
               gyp_p0[k] <= wsum(i_temp_31[k*DATA_WIDTH +: DATA_WIDTH],
                                 i_temp_32[k*DATA_WIDTH +: DATA_WIDTH],
                                 i_temp_33[k*DATA_WIDTH +: DATA_WIDTH]);
               gyn_p0[k] <= wsum(i_temp_11[k*DATA_WIDTH +: DATA_WIDTH],
                                 i_temp_12[k*DATA_WIDTH +: DATA_WIDTH],
                                 i_temp_13[k*DATA_WIDTH +: DATA_WIDTH]);
            end
         end
      end
   end

   // Stage 2: L1 gradient magnitude |Gx| + |Gy|
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld_p1 <= 1'b0;
         mag_p1 <= '0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            for (int k = 0; k < PARALLEL_NUM; k++)
               mag_p1[k] <= abs_diff(gxp_p0[k], gxn_p0[k]) + abs_diff(gyp_p0[k], gyn_p0[k]);
         end
      end
   end

   // Stage 3: saturate/threshold and attach frame position markers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_en   <= 1'b0;
         o_data <= '0;
         o_sof  <= 1'b0;
         o_eol  <= 1'b0;
         o_eof  <= 1'b0;
         h_cnt  <= '0;
         v_cnt  <= '0;
      end else begin
         o_en <= vld_p1;
         if (vld_p1) begin
            for (int k = 0; k < PARALLEL_NUM; k++)
               o_data[k*DATA_WIDTH +: DATA_WIDTH] <= out_pix(mag_p1[k], i_thresh);
            o_sof <= (h_cnt == '0) && (v_cnt == '0);
            o_eol <= (h_cnt == H_LAST);
            o_eof <= (h_cnt == H_LAST) && (v_cnt == V_LAST);
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
         end else begin
            o_sof <= 1'b0;
            o_eol <= 1'b0;
            o_eof <= 1'b0;
         end
      end
   end

endmodule
